noc_input_requester: RTL and testbench

- Per-input-port front end of the mesh router.
- Buffers incoming flits and computes the dimension-ordered (XY) output port from the head flit's destination.
- Raises a one-hot request toward the output-port round-robin arbiters, waits for grant, then forwards the flit to the crossbar.
- This block is the requester side of the request/grant interface the output arbiters serve.

---
 rtl/noc_input_requester.sv | 235 +++++++++++++++++++++++
 tb/tb_noc_input_requester.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_input_requester.sv
// noc_input_requester
//   Per-input-port front end of a mesh router. Buffers incoming flits in a
//   small circular FIFO, computes the XY (dimension-ordered) output port for
//   the flit at the FIFO head, raises a one-hot request toward the output
//   arbiters, and forwards the flit to the crossbar once granted.
//
//   Optional feature macro: WORMHOLE_EN
//     undefined : every flit is routed and arbitrated on its own; flit
//                 types are ignored.
//     defined   : a granted head flit locks the output port (HOLD) until the
//                 tail flit has been forwarded; body flits follow without a
//                 bubble.
//
// Ports
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   upstream flit valid
//   in_ready   out  FIFO has space (count != DEPTH)
//   in_flit    in   [FLIT_W-1:FLIT_W-2] type, [X_W-1:0] dest X,
//                   [X_W+Y_W-1:X_W] dest Y
//   req        out  one-hot request: 0 LOCAL, 1 N, 2 E, 3 S, 4 W
//   grant      in   per-output grant to this input
//   out_valid  out  one-cycle crossbar write strobe
//   out_flit   out  forwarded flit (registered)
//   out_port   out  one-hot port of out_flit
//
// FSM states
//   state   | meaning
//   IDLE    | no request; loads req from the FIFO head when non-empty
//   REQ     | req held stable, waiting for a matching grant
//   HOLD    | (WORMHOLE_EN) port locked for a packet until its tail passes

module noc_input_requester #(
    parameter int FLIT_W = 34,
    parameter int DEPTH  = 4,
    parameter int X_W    = 2,
    parameter int Y_W    = 2,
    parameter int MY_X   = 0,
    parameter int MY_Y   = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FLIT_W-1:0] in_flit,
    output logic [4:0]        req,
    input  logic [4:0]        grant,
    output logic              out_valid,
    output logic [FLIT_W-1:0] out_flit,
    output logic [4:0]        out_port
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [X_W-1:0]   MY_X_C  = X_W'(MY_X);
    localparam logic [Y_W-1:0]   MY_Y_C  = Y_W'(MY_Y);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [4:0] PORT_L = 5'b00001;
    localparam logic [4:0] PORT_N = 5'b00010;
    localparam logic [4:0] PORT_E = 5'b00100;
    localparam logic [4:0] PORT_S = 5'b01000;
    localparam logic [4:0] PORT_W = 5'b10000;

`ifdef WORMHOLE_EN
    localparam logic [1:0] TYPE_HEAD = 2'b01;
    localparam logic [1:0] TYPE_TAIL = 2'b11;
`endif

`ifdef WORMHOLE_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1
    } state_t;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [4:0]         req_q, req_d;
    logic               out_valid_q, out_valid_d;
    logic [FLIT_W-1:0]  out_flit_q, out_flit_d;
    logic [4:0]         out_port_q, out_port_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [FLIT_W-1:0]  mem_q [DEPTH];

    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              granted;
    logic [FLIT_W-1:0] head_flit;

    // XY routing: resolve X first, then Y, else deliver locally.
    function automatic logic [4:0] route_xy(input logic [FLIT_W-1:0] f);
        logic [X_W-1:0] dx;
        logic [Y_W-1:0] dy;
        dx = f[X_W-1:0];
        dy = f[X_W+Y_W-1:X_W];
        if (dx > MY_X_C)      return PORT_E;
        else if (dx < MY_X_C) return PORT_W;
        else if (dy > MY_Y_C) return PORT_N;
        else if (dy < MY_Y_C) return PORT_S;
        else                  return PORT_L;
    endfunction

    assign fifo_empty = (count_q == '0);
    assign in_ready   = (count_q != DEPTH_C);
    // A full FIFO deasserts in_ready, so in_valid while full never writes.
    assign push       = in_valid && in_ready;
    assign granted    = |(grant & req_q);
    assign head_flit  = mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        out_valid_d = 1'b0;
        out_flit_d  = out_flit_q;
        out_port_d  = out_port_q;
        pop         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_d = '0;
                if (!fifo_empty) begin
                    req_d   = route_xy(head_flit);
                    state_d = ST_REQ;
                end
            end

            // The FIFO is never empty here: REQ is entered only with a
            // buffered head, and only REQ/HOLD pop.
            ST_REQ: begin
                if (granted) begin
                    pop         = 1'b1;
                    out_valid_d = 1'b1;
                    out_flit_d  = head_flit;
                    out_port_d  = req_q;
                    req_d       = '0;
                    state_d     = ST_IDLE;
`ifdef WORMHOLE_EN
                    if (head_flit[FLIT_W-1 -: 2] == TYPE_HEAD) begin
                        req_d   = req_q;
                        state_d = ST_HOLD;
                    end
`endif
                end
            end

`ifdef WORMHOLE_EN
            // Every flit here rides the held port; stray head/single types
            // are treated as body.
            ST_HOLD: begin
                if (!fifo_empty && granted) begin
                    pop         = 1'b1;
                    out_valid_d = 1'b1;
                    out_flit_d  = head_flit;
                    out_port_d  = req_q;
                    if (head_flit[FLIT_W-1 -: 2] == TYPE_TAIL) begin
                        req_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
`endif

            default: begin
                req_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            out_port_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            out_port_q  <= out_port_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_flit;
        end
    end

    assign req       = req_q;
    assign out_valid = out_valid_q;
    assign out_flit  = out_flit_q;
    assign out_port  = out_port_q;

endmodule

// File: tb/tb_noc_input_requester.sv
module tb_noc_input_requester;

    localparam int FLIT_W = 34;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [FLIT_W-1:0] in_flit = '0;
    logic [4:0]        req;
    logic [4:0]        grant = '0;
    logic              out_valid;
    logic [FLIT_W-1:0] out_flit;
    logic [4:0]        out_port;

    noc_input_requester #(
        .FLIT_W(FLIT_W), .DEPTH(DEPTH), .X_W(2), .Y_W(2), .MY_X(1), .MY_Y(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_flit(in_flit), .req(req), .grant(grant), .out_valid(out_valid),
        .out_flit(out_flit), .out_port(out_port)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_out  = 0;

    // Reference model: a queue of buffered flits plus "is a request
    // outstanding, and for which port", and (wormhole) "is a packet open".
    logic [FLIT_W-1:0] mq[$];
    bit                m_busy = 0;
    bit                m_hold = 0;
    logic [4:0]        m_port = '0;
    bit                exp_ov = 0;
    logic [FLIT_W-1:0] exp_flit = '0;
    logic [4:0]        exp_port = '0;

    function automatic logic [4:0] route(input logic [FLIT_W-1:0] f);
        int x, y;
        x = int'(f[1:0]);
        y = int'(f[3:2]);
        if (x > 1)      return 5'b00100;
        else if (x < 1) return 5'b10000;
        else if (y > 1) return 5'b00010;
        else if (y < 1) return 5'b01000;
        else            return 5'b00001;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit pop, push;
        logic [FLIT_W-1:0] f;
        pop  = 0;
        push = in_valid && (mq.size() < DEPTH);
        exp_ov = 0;
        if (m_busy && ((grant & m_port) != 0) && mq.size() > 0) begin
            pop      = 1;
            f        = mq[0];
            exp_ov   = 1;
            exp_flit = f;
            exp_port = m_port;
`ifdef WORMHOLE_EN
            if (m_hold) begin
                if (f[FLIT_W-1 -: 2] == 2'b11) begin
                    m_busy = 0;
                    m_hold = 0;
                end
            end else if (f[FLIT_W-1 -: 2] == 2'b01) begin
                m_hold = 1;
            end else begin
                m_busy = 0;
            end
`else
            m_busy = 0;
`endif
        end else if (!m_busy && mq.size() > 0) begin
            m_busy = 1;
            m_port = route(mq[0]);
        end
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(in_flit);
    endtask

    task automatic model_reset();
        mq.delete();
        m_busy = 0;
        m_hold = 0;
        exp_ov = 0;
    endtask

    // One clock: advance the model on the edge, compare at the falling edge.
    task automatic step();
        @(posedge clk);
        if (reset_n) model_edge();
        @(negedge clk);
        chk("req", {59'b0, req}, {59'b0, (m_busy ? m_port : 5'b0)});
        chk("in_ready", {63'b0, in_ready}, {63'b0, (mq.size() != DEPTH)});
        chk("out_valid", {63'b0, out_valid}, {63'b0, exp_ov});
        if (exp_ov) begin
            chk("out_flit", {30'b0, out_flit}, {30'b0, exp_flit});
            chk("out_port", {59'b0, out_port}, {59'b0, exp_port});
        end
        if (out_valid) n_out++;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        grant = 5'h1f;
        for (int i = 0; i < 100; i++) begin
            if (mq.size() == 0 && !m_busy) begin
                done = 1;
                break;
            end
            // An open packet with nothing buffered needs a tail to close it.
            in_valid = m_hold && (mq.size() == 0);
            in_flit  = {2'b11, 32'h0};
            step();
        end
        in_valid = 0;
        grant    = 0;
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout actual=%0d buffered required=0", mq.size());
        end
    endtask

    task automatic push_one(input logic [FLIT_W-1:0] f);
        in_valid = 1;
        in_flit  = f;
        step();
        in_valid = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FLIT_W-1:0] f;
        logic [3:0]        rdest [5];
        logic [4:0]        rexp  [5];
        int                pushed, base;

        // ---------------- power-on reset ----------------
        model_reset();
        step();
        step();
        chk("por_req", {59'b0, req}, 64'h0);
        chk("por_out_valid", {63'b0, out_valid}, 64'h0);
        chk("por_out_flit", {30'b0, out_flit}, 64'h0);
        chk("por_out_port", {59'b0, out_port}, 64'h0);
        reset_n = 1;
        step();
        chk("por_in_ready", {63'b0, in_ready}, 64'h1);

        // ---------------- routing, MY=(1,1) ----------------
        rdest[0] = {2'd1, 2'd2}; rexp[0] = 5'b00100;
        rdest[1] = {2'd3, 2'd0}; rexp[1] = 5'b10000;
        rdest[2] = {2'd2, 2'd1}; rexp[2] = 5'b00010;
        rdest[3] = {2'd0, 2'd1}; rexp[3] = 5'b01000;
        rdest[4] = {2'd1, 2'd1}; rexp[4] = 5'b00001;
        for (int i = 0; i < 5; i++) begin
            drain();
            push_one({2'b00, 28'h0, rdest[i]});
            step();
            chk($sformatf("route%0d", i), {59'b0, req}, {59'b0, rexp[i]});
            grant = 5'h1f;
            step();
            chk($sformatf("route%0d_ov", i), {63'b0, out_valid}, 64'h1);
            grant = 0;
        end

        // ---------------- handshake latency ----------------
        drain();
        grant = 5'h1f;
        push_one(34'h2_0000_0006);
        chk("hs_edge0_req", {59'b0, req}, 64'h0);
        step();
        chk("hs_edge1_req", {59'b0, req}, 64'h04);
        chk("hs_edge1_ov", {63'b0, out_valid}, 64'h0);
        step();
        chk("hs_edge2_ov", {63'b0, out_valid}, 64'h1);
        chk("hs_edge2_flit", {30'b0, out_flit}, 64'h2_0000_0006);
        chk("hs_edge2_port", {59'b0, out_port}, 64'h04);
        step();
        chk("hs_edge3_ov", {63'b0, out_valid}, 64'h0);

        // wrong grant bit is ignored
        drain();
        grant = 5'b00001;
        push_one(34'h2_0000_0006);
        for (int i = 0; i < 4; i++) step();
        chk("wrong_grant_ov", {63'b0, out_valid}, 64'h0);
        chk("wrong_grant_req", {59'b0, req}, 64'h04);
        grant = 5'b00100;
        step();
        chk("right_grant_ov", {63'b0, out_valid}, 64'h1);

        // ---------------- full / wrap ----------------
        drain();
        for (int i = 0; i < 4; i++) push_one({2'b00, 28'(32'h100 + i), 4'($urandom)});
        chk("full_in_ready", {63'b0, in_ready}, 64'h0);
        base   = n_out;
        grant  = 5'h1f;
        pushed = 0;
        for (int i = 0; i < 200 && pushed < 6; i++) begin
            in_valid = 1;
            in_flit  = {2'b00, 28'(32'h200 + pushed), 4'($urandom)};
            if (in_ready) pushed++;
            step();
        end
        in_valid = 0;
        drain();
        chk("wrap_delivered", 64'(n_out - base), 64'd10);

        // ---------------- simultaneous push/pop ----------------
        for (int i = 0; i < 4; i++) push_one({2'b00, 28'(32'h300 + i), 4'($urandom)});
        in_valid = 1;
        in_flit  = {2'b00, 28'h3ff, 4'h6};
        grant    = 5'h1f;
        step();                                   // full: only the pop happens
        chk("full_pop_in_ready", {63'b0, in_ready}, 64'h1);
        in_valid = 0;
        grant    = 0;
        step();                                   // bubble, re-request with 3 held
        in_valid = 1;
        in_flit  = {2'b00, 28'h3fe, 4'h6};
        grant    = 5'h1f;
        step();                                   // push and pop together
        chk("pushpop_in_ready", {63'b0, in_ready}, 64'h1);
        in_valid = 0;
        drain();

        // ---------------- reset mid-REQ ----------------
        for (int i = 0; i < 3; i++) push_one({2'b00, 28'(32'h400 + i), 4'h6});
        chk("pre_reset_req", {59'b0, req}, 64'h04);
        reset_n = 0;
        #1;
        model_reset();
        chk("rst_req", {59'b0, req}, 64'h0);
        chk("rst_out_valid", {63'b0, out_valid}, 64'h0);
        chk("rst_in_ready", {63'b0, in_ready}, 64'h1);
        step();
        reset_n = 1;
        grant   = 5'h1f;
        base    = n_out;
        for (int i = 0; i < 5; i++) step();
        chk("post_reset_no_out", 64'(n_out - base), 64'd0);
        grant = 0;

`ifdef WORMHOLE_EN
        // ---------------- wormhole packet to E ----------------
        drain();
        push_one({2'b01, 28'h1, 4'h6});
        push_one({2'b10, 28'h2, 4'h0});
        push_one({2'b10, 28'h3, 4'h0});
        push_one({2'b11, 28'h4, 4'h0});
        grant = 5'b00100;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("wh_ov%0d", i), {63'b0, out_valid}, 64'h1);
            chk($sformatf("wh_port%0d", i), {59'b0, out_port}, 64'h04);
            chk($sformatf("wh_req%0d", i), {59'b0, req}, (i < 3) ? 64'h04 : 64'h0);
        end
        push_one({2'b00, 28'h5, 4'h2});
        step();
        drain();
`endif

        // ---------------- randomized traffic ----------------
        drain();
        for (int i = 0; i < 2000; i++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            f        = {$urandom, $urandom};
            in_flit  = f;
            grant    = ($urandom_range(0, 3) == 0) ? 5'h0 : 5'($urandom);
            step();
        end
        in_valid = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
